// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and its packing logic:
// request kinds, opcodes, funct codes, the NOP word and encoder FSM states.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8,
    KIND_J    = 4'd9
  } req_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    ST_EMIT = 1'b0,
    ST_PAD  = 1'b1
  } enc_state_e;

  // Control-transfer kinds that own a delay slot.
  function automatic logic is_ctrl_xfer(input logic [3:0] kind);
    return (kind == KIND_BEQ) || (kind == KIND_J);
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: request kind plus fields -> 32-bit MIPS word and a
// legal flag (kinds 10-15 are illegal and produce a zero word).
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Field packing per instruction format.
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (kind)
      KIND_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_ADD};
      KIND_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_SUB};
      KIND_AND:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_AND};
      KIND_OR:   word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_OR};
      KIND_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_SLT};
      KIND_LW:   word = {OP_LW, rs, rt, imm};
      KIND_SW:   word = {OP_SW, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_J:    word = {OP_J, target};
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams symbolic instruction requests into sequentially addressed MIPS words.
// Define MIPS_ENC_DELAY_SLOT_PAD_EN to append a NOP after every BEQ/J.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'((2**ADDR_W) - 1);

  logic [31:0] word_s;
  logic        legal_s;

  enc_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              full_s, out_free_s, req_ready_s, accept_s;

  mips_instr_pack u_pack (
    .kind   (req_kind),
    .rs     (req_rs),
    .rt     (req_rt),
    .rd     (req_rd),
    .imm    (req_imm),
    .target (req_target),
    .word   (word_s),
    .legal  (legal_s)
  );

  // Handshake, output register, counter and FSM next-state.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    err_d       = err_q;

    // count never exceeds DEPTH, so its top bit is exactly the full flag.
    full_s      = count_q[ADDR_W];
    out_free_s  = !out_valid_q || out_ready;
    req_ready_s = !full_s && out_free_s && (state_q == ST_EMIT);
    accept_s    = req_valid && req_ready_s;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (reset || clear) begin
      state_d     = ST_EMIT;
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_data_d  = 32'h0000_0000;
      count_d     = '0;
      err_d       = 1'b0;
`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
    end else if (state_q == ST_PAD) begin
      if (out_free_s) begin
        out_valid_d = 1'b1;
        out_addr_d  = count_q[ADDR_W-1:0];
        out_data_d  = NOP;
        count_d     = count_q + 1'b1;
        state_d     = ST_EMIT;
      end else begin
        state_d     = ST_PAD;
      end
`endif
    end else if (accept_s) begin
      if (legal_s) begin
        out_valid_d = 1'b1;
        out_addr_d  = count_q[ADDR_W-1:0];
        out_data_d  = word_s;
        count_d     = count_q + 1'b1;
`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
        // A branch in the last slot fills the image; there is no room for a pad.
        if (is_ctrl_xfer(req_kind) && (count_q != LAST_ADDR)) begin
          state_d = ST_PAD;
        end else begin
          state_d = ST_EMIT;
        end
`endif
      end else begin
        err_d = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMIT;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= 32'h0000_0000;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign full        = full_s;
  assign err_illegal = err_q;

endmodule
